// File: rtl/delay_arbiter_pkg.sv
// rtl/delay_arbiter_pkg.sv - shared types, defaults and round-robin pick function
package delay_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 32;

    // Widest arbiter the pick function supports; narrower ones zero-extend.
    localparam int MAX_REQ  = 16;
    localparam int MAX_ID_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // Scan from ptr+1 upward, wrapping at num_req; the first asserted request wins.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0]  req,
        input logic [MAX_ID_W-1:0] ptr,
        input int unsigned         num_req
    );
        pick_t       res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if (k <= num_req && idx < MAX_REQ && !res.valid && req[idx[MAX_ID_W-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = idx[MAX_ID_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/delay_arbiter_if.sv
// rtl/delay_arbiter_if.sv - requester-side bundle of the shared delay arbiter
interface delay_arbiter_if
    import delay_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] delay_in;
    logic                      abort;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        done;
    logic                      busy;
    logic [ID_W-1:0]           grant_id;

    modport master (
        output req, delay_in, abort,
        input  ack, done, busy, grant_id
    );

    modport slave (
        input  req, delay_in, abort,
        output ack, done, busy, grant_id
    );

endinterface

// File: rtl/delay_arbiter_rr_arbiter.sv
// rtl/delay_arbiter_rr_arbiter.sv - combinational round-robin arbiter
module rr_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant,
    output logic               grant_valid
);

    pick_t pick;

    // Widen to the package function's fixed width; the range guard is always true for a real winner.
    always_comb begin
        pick        = rr_pick(MAX_REQ'(req), MAX_ID_W'(ptr), NUM_REQ);
        grant       = pick.idx[ID_W-1:0];
        grant_valid = pick.valid && (int'(pick.idx) < NUM_REQ);
    end

endmodule

// File: rtl/delay_arbiter.sv
// rtl/delay_arbiter.sv - one delay counter time-shared among round-robin requesters
module delay_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input logic             clk,
    input logic             rst_n,
    delay_arbiter_if.slave  bus
);

    state_t            state, state_n;
    logic [DATA_W-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] dly, dly_n;
    logic [ID_W-1:0]   ptr, ptr_n;
    logic [ID_W-1:0]   gid, gid_n;
    logic              first, first_n;

    logic [ID_W-1:0]   pick;
    logic              pick_valid;
    logic [DATA_W-1:0] delay_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign delay_arr[i] = bus.delay_in[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req         (bus.req),
        .ptr         (ptr),
        .grant       (pick),
        .grant_valid (pick_valid)
    );

    // State, counter, latched delay, pointer and grantee registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dly   <= '0;
            ptr   <= ID_W'(NUM_REQ - 1);
            gid   <= '0;
            first <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dly   <= dly_n;
            ptr   <= ptr_n;
            gid   <= gid_n;
            first <= first_n;
        end
    end

    // Next-state logic: grant in IDLE, count up to the latched delay, abort wins over expiry.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dly_n   = dly;
        ptr_n   = ptr;
        gid_n   = gid;
        first_n = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = COUNT;
                    dly_n   = delay_arr[pick];
                    cnt_n   = '0;
                    gid_n   = pick;
                    first_n = 1'b1;
                end
            end
            COUNT: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    ptr_n   = gid;
                end else if (cnt < dly) begin
                    cnt_n = cnt + DATA_W'(1);
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
                ptr_n   = gid;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output decode: ack only on the first COUNT cycle, done only in DONE.
    always_comb begin
        bus.ack      = (state == COUNT && first) ? (NUM_REQ'(1) << gid) : '0;
        bus.done     = (state == DONE) ? (NUM_REQ'(1) << gid) : '0;
        bus.busy     = (state != IDLE);
        bus.grant_id = gid;
    end

endmodule

// File: tb/tb_delay_arbiter.sv
// tb/tb_delay_arbiter.sv - self-checking bench for delay_arbiter
module tb_delay_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    delay_arbiter_if #(.NUM_REQ(N), .DATA_W(W))  bus ();
    delay_arbiter_if #(.NUM_REQ(N), .DATA_W(W8)) bus8 ();

    delay_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    delay_arbiter #(.NUM_REQ(N), .DATA_W(W8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int m_ptr  = N - 1;
    int last_done = 0;
    int dly_m [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int exp_winner(input logic [N-1:0] r, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        chk("out_onehot", ($countones({bus.ack, bus.done}) <= 1), 1);
    endtask

    task automatic set_delay(input int i, input int v);
        bus.delay_in[i*W +: W] = v;
        dly_m[i] = v;
    endtask

    // Entered and left at the negedge of an IDLE cycle.
    task automatic txn(input logic [N-1:0] rv, input bit drop, input int abort_at,
                       input int new_dly, input string tag);
        int w, d, s;
        w = exp_winner(rv, m_ptr);
        d = dly_m[w];
        bus.req = rv;
        step();
        chk({tag, "_ack"}, bus.ack, 64'(1) << w);
        chk({tag, "_gid"}, bus.grant_id, w);
        chk({tag, "_busy"}, bus.busy, 1);
        if (drop) bus.req[w] = 1'b0;
        if (new_dly >= 0) bus.delay_in[w*W +: W] = new_dly;
        s = 0;
        if (abort_at >= 0) begin
            while (s < abort_at) begin
                step();
                s++;
            end
            bus.abort = 1'b1;
            step();
            bus.abort = 1'b0;
            chk({tag, "_abort_busy"}, bus.busy, 0);
            chk({tag, "_abort_done"}, bus.done, 0);
            m_ptr = w;
            return;
        end
        while (bus.done == '0 && s < d + 8) begin
            step();
            s++;
            if (bus.done == '0) chk({tag, "_no_reack"}, bus.ack, 0);
        end
        chk({tag, "_latency"}, s, d + 1);
        chk({tag, "_done"}, bus.done, 64'(1) << w);
        last_done = cyc;
        m_ptr = w;
        step();
        chk({tag, "_idle"}, bus.busy, 0);
        chk({tag, "_gid_hold"}, bus.grant_id, w);
    endtask

    initial begin
        int prev, start, s, w, ab;
        bit seen;
        logic [N-1:0] rv;

        bus.req = '0;  bus.delay_in = '0;  bus.abort = 1'b0;
        bus8.req = '0; bus8.delay_in = '0; bus8.abort = 1'b0;
        for (int i = 0; i < N; i++) dly_m[i] = 0;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_ack", bus.ack, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_gid", bus.grant_id, 0);
        rst_n = 1'b1;

        set_delay(0, 3);
        txn(4'b0001, 1'b1, -1, -1, "first");

        set_delay(2, 10);
        txn(4'b0100, 1'b1, 3, -1, "abort");
        set_delay(0, 1);
        txn(4'b0001, 1'b1, -1, -1, "after_abort");

        set_delay(1, 100);
        bus.req = 4'b0010;
        start = cyc;
        step();
        chk("rmid_ack", bus.ack, 4'b0010);
        bus.req = '0;
        seen = 1'b0;
        while (cyc - start < 20) begin
            step();
            if (bus.done != '0) seen = 1'b1;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rmid_ack0", bus.ack, 0);
        chk("rmid_done0", bus.done, 0);
        chk("rmid_busy0", bus.busy, 0);
        chk("rmid_gid0", bus.grant_id, 0);
        chk("rmid_nodone", seen, 0);
        m_ptr = N - 1;

        for (int i = 0; i < N; i++) set_delay(i, 0);
        for (int k = 0; k < 5; k++) begin
            prev = last_done;
            txn(4'b1111, 1'b0, -1, -1, "rr");
            chk("rr_order", bus.grant_id, k % N);
            if (k > 0) chk("rr_period", last_done - prev, 3);
        end
        bus.req = '0;

        set_delay(2, 2);
        txn(4'b0100, 1'b1, 2, -1, "abort_expiry");

        set_delay(3, 5);
        txn(4'b1000, 1'b1, -1, 50, "stable");
        set_delay(3, 50);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) set_delay(i, $urandom_range(0, 6));
            rv = N'($urandom_range(1, (1 << N) - 1));
            w = exp_winner(rv, m_ptr);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, dly_m[w])) : -1;
            txn(rv, 1'($urandom_range(0, 1)), ab, -1, "rnd");
        end
        bus.req = '0;

        bus8.delay_in = '0;
        bus8.delay_in[7:0] = 8'd255;
        bus8.req = 4'b0001;
        step();
        chk("w8_ack", bus8.ack, 4'b0001);
        bus8.req = '0;
        s = 0;
        while (bus8.done == '0 && s < 300) begin
            step();
            s++;
        end
        chk("w8_latency", s, 256);
        chk("w8_done", bus8.done, 4'b0001);
        step();
        chk("w8_idle", bus8.busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
